// File: rtl/soc_ram_banked_ctrl.sv
// rtl/soc_ram_banked_ctrl.sv - banked on-chip SRAM controller with request handshake and wait states
// Define SOC_RAM_ERR_CNT_EN to add the unmapped-access counter and last-bad-address capture.
module soc_ram_banked_ctrl #(
  parameter int ADDRBITSIZE = 16,
  parameter int DATABITSIZE = 32,
  parameter int NUM_BANKS = 2,
  parameter logic [NUM_BANKS*ADDRBITSIZE-1:0] BANK_BASE = {16'h2000, 16'h0000},
  parameter logic [NUM_BANKS*ADDRBITSIZE-1:0] BANK_DEPTH = {16'd256, 16'd8},
  parameter int WAIT_STATES = 1,
  parameter logic [DATABITSIZE-1:0] BAD_DATA = 32'hBAD1BAD1
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     wen,
  input  logic                     ren,
  input  logic [ADDRBITSIZE-1:0]   addr,
  input  logic [DATABITSIZE-1:0]   wdata,
  input  logic [DATABITSIZE/8-1:0] byte_en,
  output logic [DATABITSIZE-1:0]   ram_rdata,
  output logic                     ram_wait,
  output logic                     ram_active
`ifdef SOC_RAM_ERR_CNT_EN
  ,
  output logic [15:0]              err_count,
  output logic [ADDRBITSIZE-1:0]   err_last_addr
`endif
);

  localparam int AW = ADDRBITSIZE;
  localparam int DW = DATABITSIZE;
  localparam int NL = DATABITSIZE / 8;
  localparam int SW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q;
  logic [3:0]      wait_cnt_q;
  logic [DW-1:0]   rdata_q;
  logic            op_wr_q;
  logic [SW-1:0]   bank_q;

  logic [AW-1:0]   waddr;
  logic [NUM_BANKS-1:0] bank_hit;
  logic [DW-1:0]   bank_rd [NUM_BANKS];
  logic [SW-1:0]   sel;
  logic            hit;
  logic            req;
  logic            accept;
  logic            unused_addr_bits;

  assign waddr  = {2'b00, addr[AW-1:2]};
  assign req    = wen | ren;
  assign accept = (state_q == S_IDLE) && req && hit;
  assign unused_addr_bits = ^addr[1:0];

  // Walk from the top bank down so the lowest-index hit is the one left standing.
  always_comb begin
    sel = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (bank_hit[b]) sel = SW'(b);
    end
  end
  assign hit = |bank_hit;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    localparam logic [AW-1:0] BASE  = BANK_BASE[b*AW +: AW];
    localparam logic [AW-1:0] DEPTH = BANK_DEPTH[b*AW +: AW];
    localparam int D  = int'(DEPTH);
    localparam int IW = (D > 1) ? $clog2(D) : 1;

    logic [DW-1:0] mem_q [D];
    logic [AW-1:0] off;

    // The >= guard keeps the offset compare from seeing a wrapped difference.
    assign off         = waddr - BASE;
    assign bank_hit[b] = (waddr >= BASE) && (off < DEPTH);
    assign bank_rd[b]  = mem_q[off[IW-1:0]];

    always_ff @(posedge clk) begin
      if (!RST && accept && wen && (sel == SW'(b))) begin
        for (int l = 0; l < NL; l++) begin
          if (byte_en[l]) mem_q[off[IW-1:0]][l*8 +: 8] <= wdata[l*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      op_wr_q    <= 1'b0;
      bank_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_wr_q    <= wen;
            bank_q     <= sel;
            wait_cnt_q <= '0;
            // A combined wen+ren is a write, so it returns an all-zero word.
            rdata_q    <= wen ? '0 : bank_rd[sel];
            state_q    <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_q <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ram_wait   = 1'b0;
    ram_active = 1'b0;
    ram_rdata  = '0;
    if (!RST) begin
      case (state_q)
        S_IDLE: begin
          ram_active = hit;
          ram_wait   = hit && req;
          if (!hit) ram_rdata = BAD_DATA;
        end
        S_WAIT: begin
          ram_active = 1'b1;
          ram_wait   = 1'b1;
        end
        S_RESP: begin
          ram_active = 1'b1;
          ram_rdata  = op_wr_q ? '0 : rdata_q;
        end
        default: begin
          ram_active = 1'b0;
        end
      endcase
    end
  end

  logic unused_bank_q;
  assign unused_bank_q = ^bank_q;

`ifdef SOC_RAM_ERR_CNT_EN
  logic [15:0]   err_cnt_q;
  logic [AW-1:0] err_addr_q;

  always_ff @(posedge clk) begin
    if (RST) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else if ((state_q == S_IDLE) && req && !hit) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      err_addr_q <= addr;
    end
  end

  assign err_count     = err_cnt_q;
  assign err_last_addr = err_addr_q;
`endif

endmodule

// File: tb/tb_soc_ram_banked_ctrl.sv
// tb/tb_soc_ram_banked_ctrl.sv - randomized bench for soc_ram_banked_ctrl against a word-level memory model
module tb_soc_ram_banked_ctrl;

  localparam int WS = 1;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wen, ren;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        wait_o, active;

  logic        rst3, wen3, ren3;
  logic [15:0] addr3;
  logic [31:0] wdata3;
  logic [3:0]  be3;
  logic [31:0] rdata3;
  logic        wait3, active3;

`ifdef SOC_RAM_ERR_CNT_EN
  logic [15:0] err_cnt, err_cnt3;
  logic [15:0] err_addr, err_addr3;
`endif

  soc_ram_banked_ctrl #(.WAIT_STATES(WS)) u_dut (
    .clk(clk), .RST(rst), .wen(wen), .ren(ren), .addr(addr), .wdata(wdata),
    .byte_en(be), .ram_rdata(rdata), .ram_wait(wait_o), .ram_active(active)
`ifdef SOC_RAM_ERR_CNT_EN
    , .err_count(err_cnt), .err_last_addr(err_addr)
`endif
  );

  soc_ram_banked_ctrl #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .RST(rst3), .wen(wen3), .ren(ren3), .addr(addr3), .wdata(wdata3),
    .byte_en(be3), .ram_rdata(rdata3), .ram_wait(wait3), .ram_active(active3)
`ifdef SOC_RAM_ERR_CNT_EN
    , .err_count(err_cnt3), .err_last_addr(err_addr3)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mdl [int];
  int          err_cnt_m  = 0;
  logic [15:0] err_addr_m = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bank map as a table: bank0 words 0..7, bank1 words 0x2000..0x20FF.
  function automatic bit map_addr(input logic [15:0] a, output int wa);
    int base [2];
    int depth [2];
    base[0] = 0;      depth[0] = 8;
    base[1] = 'h2000; depth[1] = 256;
    wa = int'(a) / 4;
    for (int b = 0; b < 2; b++) begin
      if (wa >= base[b] && (wa - base[b]) < depth[b]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic access(input bit w, input bit r, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] b, output bit in_resp);
    int          wa;
    bit          hit;
    logic [31:0] exp_rd;
    logic [31:0] cur;
    hit = map_addr(a, wa);
    in_resp = 1'b0;
    @(negedge clk);
    wen = w; ren = r; addr = a; wdata = d; be = b;
    #1;
    check("idle_active", {31'd0, active}, {31'd0, hit});
    check("idle_wait", {31'd0, wait_o}, {31'd0, hit & (w | r)});
    check("idle_rdata", rdata, hit ? 32'h0 : BAD);
    if (!hit || !(w | r)) begin
      if (!hit && (w | r)) begin
        if (err_cnt_m != 'hFFFF) err_cnt_m++;
        err_addr_m = a;
      end
      @(posedge clk);
      #1;
`ifdef SOC_RAM_ERR_CNT_EN
      check("err_count", {16'd0, err_cnt}, 32'(err_cnt_m));
      check("err_last_addr", {16'd0, err_addr}, {16'd0, err_addr_m});
`endif
      return;
    end
    exp_rd = 32'h0;
    if (w) begin
      cur = mdl[wa];
      for (int l = 0; l < 4; l++) if (b[l]) cur[l*8 +: 8] = d[l*8 +: 8];
      mdl[wa] = cur;
    end else begin
      exp_rd = mdl[wa];
    end
    @(posedge clk);
    for (int k = 0; k < WS; k++) begin
      @(negedge clk);
      #1;
      check("wait_wait", {31'd0, wait_o}, 32'd1);
      check("wait_active", {31'd0, active}, 32'd1);
      check("wait_rdata", rdata, 32'h0);
      addr = 16'($urandom);
      wdata = $urandom;
    end
    @(negedge clk);
    #1;
    check("resp_wait", {31'd0, wait_o}, 32'd0);
    check("resp_active", {31'd0, active}, 32'd1);
    check("resp_rdata", rdata, exp_rd);
    wen = 1'b0; ren = 1'b0;
    in_resp = 1'b1;
  endtask

  initial begin
    bit          rsp;
    logic [15:0] edges [6];
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    bit          w, r;
    int          opc;
    edges = '{16'h001C, 16'h0020, 16'h83FC, 16'h8400, 16'h7FFC, 16'h0000};

    rst = 1'b1; wen = 1'b1; ren = 1'b0; addr = 16'h0004; wdata = 32'hFFFF0000; be = 4'hF;
    rst3 = 1'b1; wen3 = 1'b0; ren3 = 1'b1; addr3 = 16'h8000; wdata3 = '0; be3 = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_wait", {31'd0, wait_o}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst3_active", {31'd0, active3}, 32'd0);
`ifdef SOC_RAM_ERR_CNT_EN
    check("rst_err_count", {16'd0, err_cnt}, 32'd0);
`endif
    rst = 1'b0; wen = 1'b0; rst3 = 1'b0; ren3 = 1'b0;

    for (int i = 0; i < 8; i++) access(1, 0, 16'(i * 4), 32'h0, 4'hF, rsp);
    for (int i = 0; i < 256; i++) access(1, 0, 16'(32'h8000 + i * 4), 32'h0, 4'hF, rsp);

    access(1, 0, 16'h0004, 32'hDEADBEEF, 4'hF, rsp);
    access(0, 1, 16'h0004, 32'h0, 4'h0, rsp);
    access(1, 0, 16'h8000, 32'h11223344, 4'hF, rsp);
    access(1, 0, 16'h8000, 32'hAABBCCDD, 4'b0101, rsp);
    access(0, 1, 16'h8000, 32'h0, 4'h0, rsp);
    access(0, 1, 16'h0020, 32'h0, 4'h0, rsp);
    access(0, 1, 16'h83FC, 32'h0, 4'h0, rsp);
    access(0, 1, 16'h001C, 32'h0, 4'h0, rsp);
    access(0, 1, 16'h8400, 32'h0, 4'h0, rsp);
    access(1, 1, 16'h0008, 32'h5A5A5A5A, 4'hF, rsp);
    access(0, 1, 16'h0008, 32'h0, 4'h0, rsp);
    // Present the next request during RESP; it must wait for the following IDLE.
    access(1, 0, 16'h8010, 32'hCAFEF00D, 4'hF, rsp);
    wen = 1'b0; ren = 1'b1; addr = 16'h8010;
    access(0, 1, 16'h8010, 32'h0, 4'h0, rsp);

    // Reset during a WAIT_STATES=3 read, then a write held under reset.
    @(negedge clk);
    wen3 = 1'b1; addr3 = 16'h000C; wdata3 = 32'h12345678; be3 = 4'hF;
    #1;
    check("d3_wacc_wait", {31'd0, wait3}, 32'd1);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("d3_wwait", {31'd0, wait3}, 32'd1);
    end
    @(negedge clk);
    #1;
    check("d3_wresp_wait", {31'd0, wait3}, 32'd0);
    check("d3_wresp_rdata", rdata3, 32'h0);
    wen3 = 1'b0;
    @(negedge clk);
    ren3 = 1'b1;
    #1;
    check("d3_racc_wait", {31'd0, wait3}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("d3_rwait", {31'd0, wait3}, 32'd1);
    rst3 = 1'b1; ren3 = 1'b0; wen3 = 1'b1; wdata3 = 32'hFFFFFFFF;
    #1;
    check("d3_rst_wait", {31'd0, wait3}, 32'd0);
    check("d3_rst_active", {31'd0, active3}, 32'd0);
    check("d3_rst_rdata", rdata3, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("d3_rst2_wait", {31'd0, wait3}, 32'd0);
    check("d3_rst2_active", {31'd0, active3}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst3 = 1'b0; wen3 = 1'b0;
    #1;
    check("d3_post_active", {31'd0, active3}, 32'd1);
    check("d3_post_wait", {31'd0, wait3}, 32'd0);
    ren3 = 1'b1;
    #1;
    check("d3_post_racc", {31'd0, wait3}, 32'd1);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("d3_post_rwait", {31'd0, wait3}, 32'd1);
    end
    @(negedge clk);
    #1;
    check("d3_post_resp_wait", {31'd0, wait3}, 32'd0);
    check("d3_post_rdata", rdata3, 32'h12345678);
    ren3 = 1'b0;

    rsp = 1'b0;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 16'($urandom_range(0, 7) * 4);
        1:       a = 16'(32'h8000 + $urandom_range(0, 255) * 4);
        2:       a = 16'($urandom);
        default: a = edges[$urandom_range(0, 5)];
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      d = $urandom;
      b = 4'($urandom);
      opc = $urandom_range(0, 5);
      w = (opc <= 1) || (opc == 4);
      r = (opc == 2) || (opc == 3) || (opc == 4);
      if (rsp && $urandom_range(0, 1) == 1) begin
        wen = w; ren = r; addr = a; wdata = d; be = b;
      end
      access(w, r, a, d, b, rsp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
